// File: rtl/mips_muldiv_ctrl.sv
// MIPS multiply/divide unit: 32-iteration shift-add / restoring divide
// with sign fixup, HI/LO registers and pipeline stall generation.
module mips_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_hi,
  input  logic                  rd_lo,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    rs_raw_q, rs_raw_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            rs_neg, rt_neg;
  logic [W-1:0]    rs_mag, rt_mag;
  logic [W:0]      mul_sum;
  logic [W+1:0]    div_try;
  logic [2*W-1:0]  mul_res;
  logic [W-1:0]    quo, rem;

  always_comb begin
    rs_neg  = ~op[0] & rs_data[W-1];
    rt_neg  = ~op[0] & rt_data[W-1];
    rs_mag  = rs_neg ? -rs_data : rs_data;
    rt_mag  = rt_neg ? -rt_data : rt_data;
    mul_sum = {1'b0, prod_q[2*W-1:W]} + {1'b0, a_q};
    div_try = {1'b0, prod_q[2*W-1:W-1]} - {2'b00, b_q};
    mul_res = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    quo     = prod_q[W-1:0];
    rem     = prod_q[2*W-1:W];

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    rs_raw_d = rs_raw_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_a_d  = rs_neg;
          neg_b_d  = rt_neg;
          a_d      = rs_mag;
          b_d      = rt_mag;
          rs_raw_d = rs_data;
          prod_d   = {{W{1'b0}}, op[1] ? rs_mag : rt_mag};
        end else begin
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_d = FIXUP;
          if (!is_div_q) begin
            prod_d = prod_q[0] ? {mul_sum, prod_q[W-1:1]}
                               : {1'b0, prod_q[2*W-1:1]};
          end else if (div_try[W+1]) begin
            prod_d = {prod_q[2*W-2:0], 1'b0};
          end else begin
            prod_d = {div_try[W-1:0], prod_q[W-2:0], 1'b1};
          end
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = mul_res[2*W-1:W];
            lo_d = mul_res[W-1:0];
          end else if (b_q == '0) begin
            dbz_d = 1'b1;
            hi_d  = rs_raw_q;
            lo_d  = '1;
          end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
            hi_d = neg_a_q ? -rem : rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rs_raw_q <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rs_raw_q <= rs_raw_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign stall       = busy & (start | rd_hi | rd_lo | mthi | mtlo);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed bench for mips_muldiv_ctrl: arithmetic results, timing,
// stall/mt* interaction, flush and mid-operation reset.
module tb_mips_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, rd_hi, rd_lo, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .flush(flush),
    .busy(busy), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input logic ed);
    int bad;
    bad = 0;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    check({tag, "_busywin"}, 64'(bad), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy0"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    tick();
    check({tag, "_pulse"}, 64'({done, div_by_zero}), 64'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rd_hi = 1'b0; rd_lo = 1'b0; flush = 1'b0; op = 2'b00;
    rs_data = '0; rt_data = '0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 64'({busy, stall, done, div_by_zero}), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    run_op("mult",   2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div",    2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",   2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divmin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0);
    run_op("div0",   2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("divu0",  2'b11, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

    // MTHI / MTLO in idle
    mthi = 1'b1; wr_data = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h9ABC_DEF0;
    tick();
    mtlo = 1'b0;
    check("mthi", 64'(hi), 64'h1234_5678);
    check("mtlo", 64'(lo), 64'h9ABC_DEF0);

    // flush together with start in idle: not accepted
    start = 1'b1; flush = 1'b1; op = 2'b00;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start", 64'(busy), 64'd0);

    // stall, mtlo while busy, second start re-presented
    op = 2'b00; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rd_lo = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
    bad = 0;
    for (int c = 5; c <= 33; c++) begin
      if (c == 10) begin
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
      end
      #1;
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
      if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) bad++;
      tick();
    end
    check("stall_win", 64'(bad), 64'd0);
    check("stall_done", 64'(done), 64'd1);
    check("stall_res", {hi, lo}, {32'd0, 32'd6});
    check("stall_idle", 64'(stall), 64'd0);
    tick();
    start = 1'b0; mtlo = 1'b0; rd_lo = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    check("mt_dropped", 64'(lo), 64'd6);
    repeat (33) tick();
    check("restart_done", 64'(done), 64'd1);
    check("restart_res", {hi, lo}, {32'd0, 32'd30});
    tick();

    // flush mid-operation
    op = 2'b00; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    check("flush_nodone", 64'(bad), 64'd0);
    check("flush_hilo", {hi, lo}, {32'd0, 32'd30});

    // reset mid-operation, also with flush asserted
    op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0) bad++;
      tick();
    end
    check("rst_nodone", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
